// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART transmit frame controller. It accepts a parallel word and
//            steps the shared serializer through the start bit, the data bits
//            (LSB first), an optional parity bit and one or two stop bits. It
//            also drives the single-bit TX line.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   width       data bits per frame (>= 2); must match the serializer width
// Ports
//   CLK         system clock, rising edge active
//   Reset       asynchronous reset, active low
//   Data_valid  word-available strobe; only sampled in IDLE
//   P_data      parallel word; the LSB is sent first
//   PAR_EN      1 = append a parity bit after the data bits
//   PAR_TYP     0 = even parity, 1 = odd parity
//   STOP2       1 = two stop bits, 0 = one stop bit
//   Ser_data    current serializer output bit
//   Ser_EN      serializer shift enable (high for width cycles per frame)
//   Busy        frame in progress; also the serializer load gate
//   TX_OUT      UART line, idles high
//   Frame_done  one-cycle pulse during the final stop-bit cycle
// ============================================================================
module uart_tx_ctrl #(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Data_valid,
  input  logic [width-1:0] P_data,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             STOP2,
  input  logic             Ser_data,
  output logic             Ser_EN,
  output logic             Busy,
  output logic             TX_OUT,
  output logic             Frame_done
);

  localparam int              CNT_W    = $clog2(width);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [width-1:0]   data_q, data_d;
  logic               par_en_q, par_en_d;
  logic               par_typ_q, par_typ_d;
  logic               stop2_q, stop2_d;
  logic               parity_bit;

  // Parity comes from the latched word, so it is stable for the whole frame
  // regardless of what the source does with P_data afterwards.
  assign parity_bit = (^data_q) ^ par_typ_q;

  // --------------------------------------------------------------------------
  // State and frame-context registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;

    case (state_q)
      ST_IDLE: begin
        // The serializer loads on this same edge (it sees Busy=0), so the
        // controller and the serializer hold the same word from here on.
        if (Data_valid) begin
          data_d    = P_data;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          stop2_d   = STOP2;
          cnt_d     = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        // Stop counting at the last bit so that the counter never runs past
        // width-1 for widths that are not a power of two.
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP1;
      end
      ST_STOP1: begin
        state_d = stop2_q ? ST_STOP2 : ST_IDLE;
      end
      ST_STOP2: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from the state register only, so an asynchronous reset
  // drives them to their idle values immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    TX_OUT     = 1'b1;
    Ser_EN     = 1'b0;
    Busy       = (state_q != ST_IDLE);
    Frame_done = 1'b0;

    case (state_q)
      ST_IDLE:   TX_OUT = 1'b1;
      ST_START:  TX_OUT = 1'b0;
      ST_DATA: begin
        TX_OUT = Ser_data;
        Ser_EN = 1'b1;
      end
      ST_PARITY: TX_OUT = parity_bit;
      ST_STOP1: begin
        TX_OUT     = 1'b1;
        Frame_done = !stop2_q;
      end
      ST_STOP2: begin
        TX_OUT     = 1'b1;
        Frame_done = 1'b1;
      end
      default:   TX_OUT = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Self-checking bench for uart_tx_ctrl (width = 8). A small
//            serializer model supplies Ser_data; expected line patterns are
//            hand-computed constants held in a vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

  logic       CLK;
  logic       Reset;
  logic       Data_valid;
  logic [7:0] P_data;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic       Ser_data;
  logic       Ser_EN;
  logic       Busy;
  logic       TX_OUT;
  logic       Frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_ctrl #(.width(8)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Data_valid (Data_valid),
    .P_data     (P_data),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .Ser_data   (Ser_data),
    .Ser_EN     (Ser_EN),
    .Busy       (Busy),
    .TX_OUT     (TX_OUT),
    .Frame_done (Frame_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Serializer model: loads when Busy=0 and Data_valid=1, shifts right on Ser_EN.
  logic [7:0] ser_q;
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)                   ser_q <= 8'h00;
    else if (!Busy && Data_valid) ser_q <= P_data;
    else if (Ser_EN)              ser_q <= {1'b0, ser_q[7:1]};
  end
  assign Ser_data = ser_q[0];

  // exp_bits[k] = TX_OUT in cycle k after the accept edge (k=0 is START).
  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_typ;
    logic        stop2;
    logic [11:0] exp_bits;
    int          len;
    bit          inject;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one frame and checks all outputs every cycle. abort_at >= 0 drops
  // Reset in the middle of that cycle and returns once Reset is released.
  task automatic run_frame(input vec_t v, input string tag, input int abort_at);
    @(negedge CLK);
    P_data     = v.data;
    PAR_EN     = v.par_en;
    PAR_TYP    = v.par_typ;
    STOP2      = v.stop2;
    Data_valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_valid = 1'b0;
    // Scramble the configuration: only the latched copy may matter now.
    P_data  = ~v.data;
    PAR_EN  = ~v.par_en;
    PAR_TYP = ~v.par_typ;
    STOP2   = ~v.stop2;
    for (int k = 0; k < v.len; k++) begin
      chk($sformatf("%s tx c%0d", tag, k), 32'(TX_OUT), 32'(v.exp_bits[k]));
      chk($sformatf("%s busy c%0d", tag, k), 32'(Busy), 32'd1);
      chk($sformatf("%s ser_en c%0d", tag, k), 32'(Ser_EN), 32'(k >= 1 && k <= 8));
      chk($sformatf("%s done c%0d", tag, k), 32'(Frame_done), 32'(k == v.len - 1));
      if (k == abort_at) begin
        #3;
        Reset = 1'b0;
        #1;
        chk($sformatf("%s rst tx", tag), 32'(TX_OUT), 32'd1);
        chk($sformatf("%s rst busy", tag), 32'(Busy), 32'd0);
        chk($sformatf("%s rst ser_en", tag), 32'(Ser_EN), 32'd0);
        chk($sformatf("%s rst done", tag), 32'(Frame_done), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        return;
      end
      if (v.inject && k == 3) begin
        Data_valid = 1'b1;
        P_data     = 8'hFF;
      end
      if (v.inject && k == 4) begin
        Data_valid = 1'b0;
      end
      @(posedge CLK);
      #1;
    end
    chk($sformatf("%s idle tx", tag), 32'(TX_OUT), 32'd1);
    chk($sformatf("%s idle busy", tag), 32'(Busy), 32'd0);
    chk($sformatf("%s idle done", tag), 32'(Frame_done), 32'd0);
  endtask

  // Held-valid pattern for 0x55, no parity, one stop: 10 frame cycles + 1 idle.
  logic [10:0] rep_tx;
  logic [10:0] rep_busy;

  initial begin
    // A5 no parity, 1 stop: 0,1,0,1,0,0,1,0,1,1
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 12'b0011_0100_1010, 10, 1'b0};
    // A5 even parity (bit 0): 0,1,0,1,0,0,1,0,1,0,1
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 12'b0101_0100_1010, 11, 1'b0};
    // A5 odd parity (bit 1): 0,1,0,1,0,0,1,0,1,1,1
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 12'b0111_0100_1010, 11, 1'b0};
    // 07 even parity (bit 1): 0,1,1,1,0,0,0,0,0,1,1
    vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b0, 12'b0110_0000_1110, 11, 1'b0};
    // 3C even parity, 2 stops: 0,0,0,1,1,1,1,0,0,0,1,1
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b1, 12'b1100_0111_1000, 12, 1'b0};
    // 00 with an ignored 0xFF strobe mid-frame: 0 x9, then stop 1
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 12'b0010_0000_0000, 10, 1'b1};

    rep_tx   = 11'b110_1010_1010;
    rep_busy = 11'b011_1111_1111;

    Reset      = 1'b0;
    Data_valid = 1'b0;
    P_data     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    STOP2      = 1'b0;

    #3;
    chk("reset tx", 32'(TX_OUT), 32'd1);
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset ser_en", 32'(Ser_EN), 32'd0);
    chk("reset done", 32'(Frame_done), 32'd0);

    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i), -1);
    end

    // Back-to-back frames with Data_valid held high.
    @(negedge CLK);
    P_data     = 8'h55;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    STOP2      = 1'b0;
    Data_valid = 1'b1;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 33; k++) begin
      chk($sformatf("held tx c%0d", k), 32'(TX_OUT), 32'(rep_tx[k % 11]));
      chk($sformatf("held busy c%0d", k), 32'(Busy), 32'(rep_busy[k % 11]));
      chk($sformatf("held done c%0d", k), 32'(Frame_done), 32'((k % 11) == 9));
      @(posedge CLK);
      #1;
    end
    Data_valid = 1'b0;
    // Let the frame in flight finish (it started at the end of cycle 32).
    repeat (12) @(posedge CLK);
    #1;
    chk("held drain busy", 32'(Busy), 32'd0);

    // Reset in DATA bit 3 (cycle 4), then a clean 0x81 frame.
    run_frame(vecs[0], "abort", 4);
    repeat (2) begin
      @(posedge CLK);
      #1;
      chk("post-reset idle busy", 32'(Busy), 32'd0);
      chk("post-reset idle tx", 32'(TX_OUT), 32'd1);
    end
    // 81 no parity, 1 stop: 0,1,0,0,0,0,0,0,1,1
    run_frame('{8'h81, 1'b0, 1'b0, 1'b0, 12'b0011_0000_0010, 10, 1'b0}, "vec81", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller for the UART transmitter. It accepts a parallel word and sequences the shared width-bit serializer through start, data, optional parity and one or two stop bits. It computes parity over the accepted word and multiplexes the single-bit TX line. It sits between the system-side data source and the serializer, and its `Busy` output is the serializer's load gate.

## Interface
- `width`, default 8: data bits per frame; must be ≥ 2 and must match the serializer `width`.
- `CLK` in 1: system clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Data_valid` in 1: word-available strobe, level-sampled.
- `P_data` in width: parallel word; LSB is transmitted first.
- `PAR_EN` in 1: 1 = insert a parity bit after the data bits.
- `PAR_TYP` in 1: 0 = even parity, 1 = odd parity.
- `STOP2` in 1: 1 = two stop bits, 0 = one stop bit.
- `Ser_data` in 1: current serializer output bit.
- `Ser_EN` out 1: serializer shift enable.
- `Busy` out 1: frame in progress; also tied to the serializer `Busy` input.
- `TX_OUT` out 1: UART line; idles high.
- `Frame_done` out 1: one-cycle pulse during the final stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2; state register is reset to IDLE.
- Accept condition: `Data_valid`=1 in IDLE, sampled at a rising edge. On that edge the block:
  - latches `P_data`, `PAR_EN`, `PAR_TYP` and `STOP2` into internal registers;
  - clears the bit counter;
  - moves to START.
- The serializer loads on the same edge, because it sees `Busy`=0 and `Data_valid`=1.
- `Data_valid` in any non-IDLE state is ignored. Nothing is queued.
- Config inputs that change mid-frame have no effect; only the values latched at accept are used.
- Transitions:
  - START → DATA after 1 cycle.
  - DATA: counter increments each cycle. When the counter reaches width−1, go to PARITY if the latched `PAR_EN`=1, else to STOP1.
  - PARITY → STOP1.
  - STOP1 → STOP2 if the latched `STOP2`=1, else → IDLE.
  - STOP2 → IDLE.
- The bit counter is $clog2(width) bits wide and is never compared beyond width−1.
- Parity bit = XOR-reduction of the latched word, XOR the latched `PAR_TYP`.
- TX_OUT mux, decoded from the state register only:
  - IDLE = 1, START = 0, DATA = `Ser_data`, PARITY = parity bit, STOP1/STOP2 = 1.
  - The mux is combinational from registered signals.
- `Ser_EN` = 1 exactly in DATA state, i.e. width cycles per frame.
- `Busy` = 1 in every state except IDLE; decoded directly from the state register.
- `Frame_done` = 1 in STOP1 when the latched `STOP2`=0, or in STOP2 otherwise.
- Reset values: state IDLE, `TX_OUT`=1, `Busy`=0, `Ser_EN`=0, `Frame_done`=0, bit counter 0, latched word 0, latched config 0.

## Timing
- Accept at edge E0. START occupies cycle E0→E1. Data bit i is on `TX_OUT` in cycle E(1+i)→E(2+i).
- Frame length = 1 + width + PAR_EN + (1 + STOP2) cycles; `Busy` is high for exactly that many cycles.
- Minimum inter-frame gap is one IDLE cycle with `TX_OUT`=1. With `Data_valid` held high, the next accept occurs on the edge that ends that IDLE cycle.
- The serializer asserts `Ser_done` one cycle after DATA ends. The controller does not depend on it.
- Reset asserted mid-frame:
  - all outputs take their reset values immediately, asynchronously;
  - `TX_OUT` returns high with no partial stop bit;
  - after release, the block waits in IDLE for a new `Data_valid`.
- `Data_valid` and reset release coincident with an edge: no accept on that edge.

## Test plan
- width=8, `P_data`=0xA5, `PAR_EN`=0, `STOP2`=0, single `Data_valid` pulse → `TX_OUT` = 0,1,0,1,0,0,1,0,1,1. `Busy` high 10 cycles. `Ser_EN` high 8 cycles. `Frame_done` pulses in cycle 10.
- 0xA5, `PAR_EN`=1, `PAR_TYP`=0 → parity bit 0, 11-cycle frame. Repeat with `PAR_TYP`=1 → parity bit 1. 0x07 even → parity bit 1.
- 0x3C, `PAR_EN`=1, `STOP2`=1 → 12-cycle frame ending 1,1. `Frame_done` only in the second stop cycle.
- `Data_valid` pulsed with 0xFF during the DATA state of a 0x00 frame → frame bits all 0. The 0xFF word is never sent. `Busy` is unaffected.
- `Data_valid` held high with `P_data`=0x55, no parity, one stop → frames repeat every 11 cycles, separated by exactly one IDLE high cycle.
- Reset driven low in DATA bit 3 → `TX_OUT`=1, `Busy`=0 and `Ser_EN`=0 immediately. After release, a 0x81 frame transmits correctly from START.
